max_pool_stream: RTL and testbench
==================================

MAX_POOL_STREAM -- requirements
Module: max_pool_stream

Interface
REQ-001 Parameter WIDTH, default 8: pixel word width in bits, two's-complement signed.
REQ-002 Parameter IMG_W, default 24: pixels per input row; SHALL be even and >= 2.
REQ-003 Parameter IMG_H, default 24: rows per input frame; SHALL be even and >= 2.
REQ-004 clk  input  1  clock; all state SHALL change on its rising edge only.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 ce  input  1  clock enable; when low, all state is frozen.
REQ-007 din_vld  input  1  din carries a valid conv-output pixel this cycle.
REQ-008 din  input  WIDTH  pixel, raster order, row-major.
REQ-009 dout_vld  output  1  one-cycle pulse marking a valid pooled pixel.
REQ-010 dout  output  WIDTH  pooled pixel, signed.
REQ-011 frame_done  output  1  one-cycle pulse, coincident with the last dout_vld of a frame.

Function
REQ-012 The block SHALL compute the 2x2 stride-2 max-pool of an IMG_W x IMG_H frame; output is (IMG_W/2) x (IMG_H/2), in raster order.
REQ-013 A pixel is accepted only when ce=1 and din_vld=1; gaps of any length between accepted pixels SHALL be tolerated.
REQ-014 Column counter 0..IMG_W-1 and row counter 0..IMG_H-1 SHALL advance per accepted pixel; column wraps to 0 after IMG_W-1 and increments row; row wraps to 0 after IMG_H-1 (next frame starts with no idle cycle).
REQ-015 Even column: pixel SHALL be held in a pair register.
REQ-016 Odd column, even row: max(pair, din) SHALL be written to line-buffer entry col/2 (IMG_W/2 entries of WIDTH bits).
REQ-017 Odd column, odd row: max(pair, din, linebuf[col/2]) SHALL be registered to dout with dout_vld=1 on the next rising edge (latency 1 cycle from the accepting edge).
REQ-018 All comparisons SHALL be signed over full WIDTH; ties keep either value (result identical).
REQ-019 dout SHALL hold its last value when dout_vld=0.
REQ-020 dout_vld SHALL be 0 in any cycle following an edge where ce=0 or no pooled result was produced.
REQ-021 frame_done SHALL pulse with the output produced from pixel (col IMG_W-1, row IMG_H-1).
REQ-022 ce=0 SHALL freeze counters, pair register, line buffer and dout; din_vld is ignored.
REQ-023 A line-buffer entry SHALL be read for an odd row before it is overwritten by the next even row; no read/write collision exists because even/odd rows alternate.

Reset
REQ-024 When rst=0 at a rising edge: column and row counters SHALL be 0, dout_vld=0, frame_done=0, dout=0, pair register=0.
REQ-025 Line-buffer contents SHALL NOT require reset; they are always written before read.
REQ-026 Reset SHALL take priority over ce and din_vld; reset mid-frame discards the partial frame and the next accepted pixel is (col 0, row 0).

Configuration
REQ-027 Macro POOL_RELU_OUT_EN: when defined, dout SHALL be max(pooled, 0) (negative results clamp to 0); when undefined, dout SHALL be the raw signed pooled value. Timing and dout_vld identical in both builds.

Verification (IMG_W=4, IMG_H=4, WIDTH=8 unless stated)
REQ-028 Frame din = 1..16 back-to-back -> dout_vld pulses carry 6, 8, 14, 16, each 1 cycle after pixels 6, 8, 14, 16; frame_done with 16.
REQ-029 Same frame with din_vld low every other cycle and ce low for 3 cycles mid-row -> identical dout sequence; no pulse during ce=0.
REQ-030 All pixels -5 except pixel 11 = -2 -> outputs -5, -5, -5, -2 (undefined macro); with POOL_RELU_OUT_EN -> 0, 0, 0, 0.
REQ-031 Mixed signs, window {127, -128, -1, 0} -> 127 (signed compare, not unsigned).
REQ-032 rst=0 asserted after pixel 7, then frame 1..16 -> outputs 6, 8, 14, 16 only; nothing from the aborted frame.
REQ-033 Two consecutive frames with no gap -> 8 outputs, 2 frame_done pulses, second-frame values correct.

Source files
------------

// File: rtl/max_pool_stream_if.sv
// Pixel stream interface for max_pool_stream.
//   master: drives ce, din_vld, din; observes dout_vld, dout, frame_done
//   slave : the pooling block
interface max_pool_stream_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic                    ce;
    logic                    din_vld;
    logic signed [WIDTH-1:0] din;
    logic                    dout_vld;
    logic signed [WIDTH-1:0] dout;
    logic                    frame_done;

    modport master (
        output ce, din_vld, din,
        input  dout_vld, dout, frame_done
    );

    modport slave (
        input  ce, din_vld, din,
        output dout_vld, dout, frame_done
    );
endinterface

// File: rtl/max_pool_stream.sv
// 2x2 stride-2 signed max-pool over a raster-order pixel stream.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-low reset
//   pix_if - slave side of max_pool_stream_if (ce, din_vld, din in;
//            dout_vld, dout, frame_done out, all outputs registered)
// Optional build macro: POOL_RELU_OUT_EN clamps negative pooled results to 0.
module max_pool_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IMG_W = 24,
    parameter int unsigned IMG_H = 24
) (
    input  logic             clk,
    input  logic             rst,
    max_pool_stream_if.slave pix_if
);
    localparam int unsigned HALF_W = IMG_W / 2;
    localparam int unsigned COL_W  = $clog2(IMG_W);
    localparam int unsigned ROW_W  = $clog2(IMG_H);
    localparam int unsigned IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    typedef logic signed [WIDTH-1:0] pix_t;

    function automatic pix_t smax(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    pix_t             pair_q, pair_d;
    pix_t             dout_q, dout_d;
    logic             dout_vld_q, dout_vld_d;
    logic             frame_done_q, frame_done_d;
    pix_t             linebuf_q [HALF_W];

    logic             accept_c;
    logic             col_last_c;
    logic             row_last_c;
    logic             lb_we_c;
    logic [IDX_W-1:0] lb_idx_c;
    pix_t             lb_wdata_c;
    pix_t             pooled_c;

    // Next-state: counters, pair register, line-buffer write and output capture
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        pair_d       = pair_q;
        dout_d       = dout_q;
        dout_vld_d   = 1'b0;
        frame_done_d = 1'b0;
        lb_we_c      = 1'b0;

        accept_c   = pix_if.ce && pix_if.din_vld;
        col_last_c = (col_q == COL_W'(IMG_W - 1));
        row_last_c = (row_q == ROW_W'(IMG_H - 1));
        lb_idx_c   = IDX_W'(col_q >> 1);
        // Horizontal pair max feeds both the line buffer (even row) and the
        // final 2x2 max (odd row, combined with the stored upper pair).
        lb_wdata_c = smax(pair_q, pix_if.din);
        pooled_c   = smax(lb_wdata_c, linebuf_q[lb_idx_c]);

        if (accept_c) begin
            if (!col_q[0]) begin
                pair_d = pix_if.din;
            end else if (!row_q[0]) begin
                lb_we_c = 1'b1;
            end else begin
`ifdef POOL_RELU_OUT_EN
                dout_d = pooled_c[WIDTH-1] ? pix_t'(0) : pooled_c;
`else
                dout_d = pooled_c;
`endif
                dout_vld_d   = 1'b1;
                frame_done_d = col_last_c && row_last_c;
            end

            if (col_last_c) begin
                col_d = '0;
                row_d = row_last_c ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // State registers; pulses clear on every edge so ce=0 never repeats a pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            dout_q       <= '0;
            dout_vld_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            pair_q       <= pair_d;
            dout_q       <= dout_d;
            dout_vld_q   <= dout_vld_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer: no reset needed, every entry is written on an even row
    // before the following odd row reads it.
    always_ff @(posedge clk) begin
        if (rst && lb_we_c) begin
            linebuf_q[lb_idx_c] <= lb_wdata_c;
        end
    end

    assign pix_if.dout       = dout_q;
    assign pix_if.dout_vld   = dout_vld_q;
    assign pix_if.frame_done = frame_done_q;
endmodule

// File: tb/tb_max_pool_stream.sv
// Directed testbench for max_pool_stream, 4x4 frame, 8-bit pixels.
module tb_max_pool_stream;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned IMG_W = 4;
    localparam int unsigned IMG_H = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    max_pool_stream_if #(.WIDTH(WIDTH)) pix_if ();

    max_pool_stream #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk    (clk),
        .rst    (rst),
        .pix_if (pix_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Captured output pulses: value, index (1..16) of the pixel accepted at the
    // same edge (0 when none was accepted), and frame_done flag.
    int got_v[$];
    int got_i[$];
    int got_f[$];
    int acc_cnt  = 0;
    int last_idx = 0;

    int frm[16];
    int exp_v[8];
    int exp_i[8];
    int exp_f[8];

    always @(posedge clk) begin
        if (!rst) begin
            acc_cnt  <= 0;
            last_idx <= 0;
        end else if (pix_if.ce && pix_if.din_vld) begin
            last_idx <= acc_cnt + 1;
            acc_cnt  <= (acc_cnt + 1) % 16;
        end else begin
            last_idx <= 0;
        end
    end

    always @(negedge clk) begin
        if (pix_if.dout_vld) begin
            got_v.push_back(int'(pix_if.dout));
            got_i.push_back(last_idx);
            got_f.push_back(int'(pix_if.frame_done));
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int post(input int x);
`ifdef POOL_RELU_OUT_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    task automatic drive(input logic c, input logic v, input int d);
        @(negedge clk);
        pix_if.ce      = c;
        pix_if.din_vld = v;
        pix_if.din     = WIDTH'(d);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, 0);
    endtask

    task automatic send_frame();
        for (int p = 0; p < 16; p++) drive(1'b1, 1'b1, frm[p]);
    endtask

    task automatic clear_caps();
        got_v.delete();
        got_i.delete();
        got_f.delete();
    endtask

    // Compare captured pulses against exp_* (first n entries), then clear.
    task automatic expect_outs(input string tag, input int n);
        check($sformatf("%s.count", tag), got_v.size(), n);
        for (int k = 0; k < n && k < got_v.size(); k++) begin
            check($sformatf("%s.val[%0d]", tag, k), got_v[k], exp_v[k]);
            check($sformatf("%s.src[%0d]", tag, k), got_i[k], exp_i[k]);
            check($sformatf("%s.fd[%0d]", tag, k), got_f[k], exp_f[k]);
        end
        clear_caps();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b0;
        pix_if.ce      = 1'b1;
        pix_if.din_vld = 1'b1;
        pix_if.din     = WIDTH'(99);
        @(negedge clk);
        @(negedge clk);
        rst            = 1'b1;
        pix_if.din_vld = 1'b0;
    endtask

    initial begin
        pix_if.ce      = 1'b0;
        pix_if.din_vld = 1'b0;
        pix_if.din     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.dout_vld", int'(pix_if.dout_vld), 0);
        check("rst.frame_done", int'(pix_if.frame_done), 0);
        check("rst.dout", int'(pix_if.dout), 0);
        rst = 1'b1;
        clear_caps();

        // Frame 1..16 back-to-back
        for (int p = 0; p < 16; p++) frm[p] = p + 1;
        send_frame();
        idle(2);
        exp_v = '{6, 8, 14, 16, 0, 0, 0, 0};
        exp_i = '{6, 8, 14, 16, 0, 0, 0, 0};
        exp_f = '{0, 0, 0, 1, 0, 0, 0, 0};
        expect_outs("seq", 4);
        idle(2);
        check("hold.dout_vld", int'(pix_if.dout_vld), 0);
        check("hold.dout", int'(pix_if.dout), 16);

        // Same frame with gaps every other cycle and ce low for 3 cycles
        // right after pixel 6 (garbage on din must be ignored)
        for (int p = 0; p < 16; p++) begin
            drive(1'b1, 1'b1, frm[p]);
            if (p == 5) repeat (3) drive(1'b0, 1'b1, 99);
            drive(1'b1, 1'b0, 77);
        end
        idle(2);
        expect_outs("gaps", 4);

        // All -5 except pixel 11 = -2
        for (int p = 0; p < 16; p++) frm[p] = -5;
        frm[10] = -2;
        send_frame();
        idle(2);
        exp_v = '{post(-5), post(-5), post(-5), post(-2), 0, 0, 0, 0};
        expect_outs("neg", 4);

        // Signed compare windows
        frm = '{127, -128, -128, -1,
                -1, 0, -128, -128,
                0, -128, -128, -128,
                -128, -128, -128, 127};
        send_frame();
        idle(2);
        exp_v = '{127, post(-1), 0, 127, 0, 0, 0, 0};
        expect_outs("signed", 4);

        // Reset after pixel 7: pixel 6's result precedes the reset, then a
        // clean frame must follow with nothing left over
        for (int p = 0; p < 7; p++) drive(1'b1, 1'b1, p + 1);
        idle(2);
        exp_v = '{6, 0, 0, 0, 0, 0, 0, 0};
        exp_i = '{6, 0, 0, 0, 0, 0, 0, 0};
        exp_f = '{0, 0, 0, 0, 0, 0, 0, 0};
        expect_outs("prerst", 1);
        do_reset();
        clear_caps();
        for (int p = 0; p < 16; p++) frm[p] = p + 1;
        send_frame();
        idle(2);
        exp_v = '{6, 8, 14, 16, 0, 0, 0, 0};
        exp_i = '{6, 8, 14, 16, 0, 0, 0, 0};
        exp_f = '{0, 0, 0, 1, 0, 0, 0, 0};
        expect_outs("postrst", 4);

        // Two consecutive frames, no gap: descending 16..1 then 101..116
        for (int p = 0; p < 16; p++) frm[p] = 16 - p;
        send_frame();
        for (int p = 0; p < 16; p++) frm[p] = 101 + p;
        send_frame();
        idle(2);
        exp_v = '{16, 14, 8, 6, 106, 108, 114, 116};
        exp_i = '{6, 8, 14, 16, 6, 8, 14, 16};
        exp_f = '{0, 0, 0, 1, 0, 0, 0, 1};
        expect_outs("twofrm", 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
